decode_control_stage: RTL and testbench

DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

---
 rtl/riscv_ctrl_pkg.sv | 44 ++++
 rtl/ctrl_decoder.sv | 44 ++++
 rtl/decode_control_stage.sv | 151 +++++++++++++++
 tb/tb_decode_control_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, ALU-op encodings, control bundle and FSM states for the decode stage.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [1:0] {RUN, LU_STALL, MUL_WAIT} state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_src_a;
    logic       branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       is_mul;
    logic       illegal;
  } ctrl_t;

  // Formats whose rs2 field is a real source operand.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct7 -> control bundle decode.
// RV32M_DECODE_EN: R-type with funct7=0000001 decodes as a multiply (is_mul).
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl
);

`ifndef RV32M_DECODE_EN
  logic unused_funct7;
  assign unused_funct7 = ^funct7;
`endif

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op    = ALU_FUNC;
        ctrl.reg_write = 1'b1;
`ifdef RV32M_DECODE_EN
        ctrl.is_mul    = (funct7 == F7_MULDIV);
`endif
      end
      OP_IALU:   begin ctrl.alu_op = ALU_FUNC; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
      OP_LOAD: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_JALR:   begin ctrl.alu_op = ALU_PASS; ctrl.alu_src = 1'b1; ctrl.is_jalr = 1'b1; ctrl.reg_write = 1'b1; end
      OP_STORE:  begin ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
      OP_BRANCH: begin ctrl.alu_op = ALU_BR; ctrl.branch = 1'b1; end
      OP_JAL:    begin ctrl.alu_op = ALU_PASS; ctrl.alu_src = 1'b1; ctrl.is_jal = 1'b1; ctrl.reg_write = 1'b1; end
      OP_LUI:    begin ctrl.alu_op = ALU_PASS; ctrl.alu_src = 1'b1; ctrl.is_lui = 1'b1; ctrl.reg_write = 1'b1; end
      OP_AUIPC:  begin ctrl.alu_op = ALU_PASS; ctrl.alu_src = 1'b1; ctrl.alu_src_a = 1'b1; ctrl.reg_write = 1'b1; end
      default:   ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_control_stage.sv
// ID stage: registered control bundle, load-use stall, multiply occupancy and flush.
// RV32M_DECODE_EN enables the multiply decode and its MUL_WAIT down-counter.
module decode_control_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            alu_op,
  output logic                  alu_src,
  output logic                  alu_src_a,
  output logic                  branch,
  output logic                  is_jal,
  output logic                  is_jalr,
  output logic                  is_lui,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  is_mul,
  output logic                  illegal,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd
);

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic                  hazard, slot_free, accept;
  ctrl_t                 dec, ctrl_q;
  state_e                state;

`ifdef RV32M_DECODE_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] cnt;
`else
  logic [3:0] unused_mul_lat;
  assign unused_mul_lat = 4'(MUL_LAT);
`endif

  // Only some instr bits feed decode, depending on REG_ADDR_W and the build.
  logic unused_instr;
  assign unused_instr = ^instr;

  assign opcode = instr[6:0];

  ctrl_decoder u_dec (
    .opcode (opcode),
    .funct7 (instr[31:25]),
    .ctrl   (dec)
  );

  assign rs1_d = instr[15 +: REG_ADDR_W];
  assign rs2_d = instr[20 +: REG_ADDR_W];
  assign rd_d  = (opcode == OP_STORE || opcode == OP_BRANCH) ? '0 : instr[7 +: REG_ADDR_W];

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == rs1_d) || (ex_rd == rs2_d && uses_rs2(opcode)));

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst_n && !flush && (state == RUN) && slot_free && !hazard;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
`ifdef RV32M_DECODE_EN
      cnt       <= '0;
`endif
    end else if (flush) begin
      state     <= RUN;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
`ifdef RV32M_DECODE_EN
      cnt       <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
      rs1       <= rs1_d;
      rs2       <= rs2_d;
      rd        <= rd_d;
`ifdef RV32M_DECODE_EN
      if (dec.is_mul) begin
        state <= MUL_WAIT;
        cnt   <= CNT_W'(MUL_LAT - 1);
      end
`endif
    end else begin
      // Nothing new this edge: an emptied slot becomes a zero bubble.
      if (slot_free) begin
        out_valid <= 1'b0;
        ctrl_q    <= '0;
        rs1       <= '0;
        rs2       <= '0;
        rd        <= '0;
      end
      case (state)
        // A bubble can only be issued into a free slot; a held output keeps priority.
        RUN:      if (in_valid && hazard && slot_free) state <= LU_STALL;
        LU_STALL: state <= RUN;
        MUL_WAIT: begin
`ifdef RV32M_DECODE_EN
          if (cnt <= CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
`else
          state <= RUN;
`endif
        end
        default:  state <= RUN;
      endcase
    end
  end

  assign alu_op     = ctrl_q.alu_op;
  assign alu_src    = ctrl_q.alu_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign branch     = ctrl_q.branch;
  assign is_jal     = ctrl_q.is_jal;
  assign is_jalr    = ctrl_q.is_jalr;
  assign is_lui     = ctrl_q.is_lui;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign is_mul     = ctrl_q.is_mul;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_decode_control_stage;
  localparam int RW = 5;
  localparam int MUL_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, ex_mem_read, flush, out_valid, out_ready;
  logic [31:0]   instr;
  logic [RW-1:0] ex_rd, rs1, rs2, rd;
  logic [1:0]    alu_op;
  logic          alu_src, alu_src_a, branch, is_jal, is_jalr, is_lui;
  logic          mem_read, mem_write, reg_write, mem_to_reg, is_mul, illegal;

  always #5 clk = ~clk;

  decode_control_stage #(.REG_ADDR_W(RW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_src(alu_src), .alu_src_a(alu_src_a), .branch(branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .is_mul(is_mul), .illegal(illegal), .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  // Bundle packed as {alu_op[13:12], alu_src, alu_src_a, branch, jal, jalr, lui,
  //                   mem_read, mem_write, reg_write, mem_to_reg, is_mul, illegal}
  wire [13:0] dut_bits = {alu_op, alu_src, alu_src_a, branch, is_jal, is_jalr, is_lui,
                          mem_read, mem_write, reg_write, mem_to_reg, is_mul, illegal};

  int checks = 0;
  int failures = 0;

  logic          m_valid;
  logic [13:0]   m_bits;
  logic [RW-1:0] m_rs1, m_rs2, m_rd;
  int            m_busy;   // cycles for which the stage refuses input regardless

  function automatic logic [13:0] ref_dec(input logic [31:0] i);
    logic [13:0] r;
    r = '0;
    case (i[6:0])
      7'b0110011: begin r[13:12] = 2'b10; r[3] = 1'b1;
`ifdef RV32M_DECODE_EN
                  r[1] = (i[31:25] == 7'b0000001);
`endif
                  end
      7'b0010011: begin r[13:12] = 2'b10; r[11] = 1; r[3] = 1; end
      7'b0000011: begin r[13:12] = 2'b00; r[11] = 1; r[5] = 1; r[3] = 1; r[2] = 1; end
      7'b1100111: begin r[13:12] = 2'b11; r[11] = 1; r[7] = 1; r[3] = 1; end
      7'b0100011: begin r[13:12] = 2'b00; r[11] = 1; r[4] = 1; end
      7'b1100011: begin r[13:12] = 2'b01; r[9] = 1; end
      7'b1101111: begin r[13:12] = 2'b11; r[11] = 1; r[8] = 1; r[3] = 1; end
      7'b0110111: begin r[13:12] = 2'b11; r[11] = 1; r[6] = 1; r[3] = 1; end
      7'b0010111: begin r[13:12] = 2'b11; r[11] = 1; r[10] = 1; r[3] = 1; end
      default:    r[0] = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic ref_haz(input logic [31:0] i, input logic mr, input logic [RW-1:0] erd);
    logic two_src;
    two_src = (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0100011) || (i[6:0] == 7'b1100011);
    return mr && (erd != 0) && ((erd == i[19:15]) || (two_src && erd == i[24:20]));
  endfunction

  function automatic logic exp_ready();
    return rst_n && !flush && (m_busy == 0) && (!m_valid || out_ready) &&
           !ref_haz(instr, ex_mem_read, ex_rd);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_bits = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_busy = 0;
  endtask

  // Advance the model on the current inputs, then move to 1 time unit past the edge.
  task automatic tick();
    logic slot, acc;
    slot = !m_valid || out_ready;
    acc  = in_valid && exp_ready();
    if (flush) begin
      m_valid = 0; m_bits = '0; m_busy = 0;
    end else if (acc) begin
      m_valid = 1;
      m_bits  = ref_dec(instr);
      m_rs1   = instr[19:15];
      m_rs2   = instr[24:20];
      m_rd    = (instr[6:0] == 7'b0100011 || instr[6:0] == 7'b1100011) ? '0 : instr[11:7];
      m_busy  = m_bits[1] ? MUL_LAT - 1 : 0;
    end else begin
      if (slot) begin m_valid = 0; m_bits = '0; end
      if (m_busy > 0) m_busy--;
      else if (in_valid && slot && ref_haz(instr, ex_mem_read, ex_rd)) m_busy = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1; in_valid = 1; instr = 32'h00012083; out_ready = 1;
    ex_rd = '0; ex_mem_read = 0; flush = 0;
    #1 rst_n = 0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (dut_bits !== 14'h0) begin failures++; $display("FAIL reset_bundle got=%0h exp=0", dut_bits); end
    checks++; if ({rs1, rs2, rd} !== '0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {rs1, rs2, rd}); end
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_lw();
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lw_valid got=%0b exp=1", out_valid); end
    checks++; if ({alu_op, mem_read, mem_to_reg} !== 4'b0011) begin failures++; $display("FAIL lw_ctrl got=%0b exp=0011", {alu_op, mem_read, mem_to_reg}); end
    checks++; if (rd !== 5'd1) begin failures++; $display("FAIL lw_rd got=%0d exp=1", rd); end
    checks++; if (dut_bits !== ref_dec(32'h00012083)) begin failures++; $display("FAIL lw_bundle got=%0h exp=%0h", dut_bits, ref_dec(32'h00012083)); end
    tick();
  endtask

  task automatic test_hazard();
    out_ready = 1; in_valid = 1; instr = 32'h002081B3; ex_rd = 5'd1; ex_mem_read = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_ready got=%0b exp=0", in_ready); end
    tick();
    ex_mem_read = 0; #1;
    checks++; if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL haz_bubble got=%0b exp=00", {in_ready, out_valid}); end
    checks++; if (dut_bits !== 14'h0) begin failures++; $display("FAIL haz_bubble_bundle got=%0h exp=0", dut_bits); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_resume got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if ({out_valid, rd, rs1, rs2} !== {1'b1, 5'd3, 5'd1, 5'd2}) begin failures++; $display("FAIL haz_issue got=%0h exp=%0h", {out_valid, rd, rs1, rs2}, {1'b1, 5'd3, 5'd1, 5'd2}); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1; in_valid = 1; instr = 32'h002081B3; ex_rd = 5'd1; ex_mem_read = 1;
    tick();
    rst_n = 0; #1;
    checks++; if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL rst_stall_held got=%0b exp=00", {in_ready, out_valid}); end
    rst_n = 1; model_reset(); ex_mem_read = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_stall_abandon got=%0b exp=1", in_ready); end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_replay got=%0b exp=0", out_valid); end
  endtask

  task automatic test_hold();
    out_ready = 0; in_valid = 1; instr = 32'h00008293;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_first_ready got=%0b exp=1", in_ready); end
    tick();
    instr = 32'h002081B3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({out_valid, in_ready, rd} !== {2'b10, 5'd5}) begin failures++; $display("FAIL hold_stable%0d got=%0h exp=%0h", k, {out_valid, in_ready, rd}, {2'b10, 5'd5}); end
      checks++; if (dut_bits !== ref_dec(32'h00008293)) begin failures++; $display("FAIL hold_bundle%0d got=%0h exp=%0h", k, dut_bits, ref_dec(32'h00008293)); end
      tick();
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if ({out_valid, rd} !== {1'b1, 5'd3}) begin failures++; $display("FAIL hold_next got=%0h exp=%0h", {out_valid, rd}, {1'b1, 5'd3}); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; instr = 32'h00208063;
    tick();
    checks++; if ({out_valid, branch, rd} !== {2'b11, 5'd0}) begin failures++; $display("FAIL flush_beq got=%0h exp=%0h", {out_valid, branch, rd}, {2'b11, 5'd0}); end
    flush = 1; instr = 32'h002081B3; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 0; in_valid = 0; #1;
    checks++; if ({out_valid, branch} !== 2'b00 || dut_bits !== 14'h0) begin failures++; $display("FAIL flush_clear got=%0h exp=0", {out_valid, dut_bits}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_run got=%0b exp=1", in_ready); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_mul();
    int n;
    out_ready = 1; in_valid = 1; instr = 32'h022081B3;
    tick();
    instr = 32'h002081B3; #1;
`ifdef RV32M_DECODE_EN
    checks++; if (is_mul !== 1'b1) begin failures++; $display("FAIL mul_flag got=%0b exp=1", is_mul); end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (n != MUL_LAT - 1) begin failures++; $display("FAIL mul_stall got=%0d exp=%0d", n, MUL_LAT - 1); end
`else
    n = 0;
    checks++; if (is_mul !== 1'b0) begin failures++; $display("FAIL mul_flag got=%0b exp=0", is_mul); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mul_nostall got=%0b exp=1 n=%0d", in_ready, n); end
`endif
    in_valid = 0;
    tick(); tick();
  endtask

  task automatic test_illegal();
    out_ready = 1; in_valid = 1; instr = 32'h1234507F;
    tick();
    in_valid = 0;
    checks++; if ({out_valid, illegal} !== 2'b11) begin failures++; $display("FAIL illegal_flag got=%0b exp=11", {out_valid, illegal}); end
    checks++; if (dut_bits[13:1] !== 13'h0) begin failures++; $display("FAIL illegal_bundle got=%0h exp=0", dut_bits[13:1]); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    int pick;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1111111};
    for (int c = 0; c < 600; c++) begin
      pick = int'($urandom_range(0, 10));
      instr = $urandom;
      instr[6:0]   = ops[pick];
      instr[19:15] = 5'($urandom_range(0, 3));
      instr[24:20] = 5'($urandom_range(0, 3));
      instr[11:7]  = 5'($urandom_range(0, 7));
      if (pick == 9) instr[31:25] = 7'b0000001;
      else if (pick == 0) instr[31:25] = 7'b0000000;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_rd       = 5'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 19) == 0);
      #1;
      checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, in_ready, exp_ready()); end
      checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if ({dut_bits, rs1, rs2, rd} !== {m_bits, m_rs1, m_rs2, m_rd}) begin failures++; $display("FAIL rnd_out c=%0d got=%0h exp=%0h", c, {dut_bits, rs1, rs2, rd}, {m_bits, m_rs1, m_rs2, m_rd}); end
      end
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lw();
    test_hazard();
    test_reset_mid_stall();
    test_hold();
    test_flush();
    test_mul();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
